// File: rtl/fetch_sequencer.sv
// fetch_sequencer: stall-aware instruction fetch controller.
// Owns the PC and issues one memory request at a time using a req/ack handshake.
// It presents each fetched word to decode through a valid/ready handshake.
// Optional macro FETCH_ALIGN_CHECK_EN: a misaligned redirect target faults,
// and so does a misaligned RESET_PC.
module fetch_sequencer #(
    parameter int unsigned            WORD      = 64,
    parameter int unsigned            INSTR_LEN = 32,
    parameter logic [WORD-1:0]        RESET_PC  = '0,
    parameter int unsigned            TIMEOUT   = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  mem_req,
    output logic [WORD-1:0]       mem_addr,
    input  logic                  mem_ack,
    input  logic [INSTR_LEN-1:0]  mem_rdata,
    output logic [INSTR_LEN-1:0]  instruction,
    output logic [WORD-1:0]       cur_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  pc_src,
    input  logic [WORD-1:0]       branch_target,
    output logic                  fault
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        FAULT
    } state_t;

    state_t          state;
    logic [WORD-1:0] pc;
    logic [CW-1:0]   wait_cnt;
    logic [CW-1:0]   cnt_inc;
    logic            timed_out;
    logic [WORD-1:0] next_pc;
    logic            reset_misaligned;
    logic            branch_misaligned;

    // The PC only changes at consume, so it doubles as the stable request address.
    assign mem_addr  = pc;
    assign cnt_inc   = wait_cnt + CW'(1);
    assign timed_out = (TIMEOUT != 0) && (cnt_inc == CW'(TIMEOUT));
    assign next_pc   = pc_src ? branch_target : cur_pc + WORD'(4);

`ifdef FETCH_ALIGN_CHECK_EN
    assign reset_misaligned  = (RESET_PC[1:0] != 2'b00);
    assign branch_misaligned = pc_src && (branch_target[1:0] != 2'b00);
`else
    assign reset_misaligned  = 1'b0;
    assign branch_misaligned = 1'b0;
`endif

    // Fetch FSM with registered handshake outputs; the async reset drops mem_req at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            cur_pc      <= RESET_PC;
            mem_req     <= 1'b0;
            instruction <= '0;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (reset_misaligned) begin
                        state <= FAULT;
                        fault <= 1'b1;
                    end else begin
                        state   <= REQ;
                        mem_req <= 1'b1;
                    end
                end
                REQ: begin
                    // An ack on the same edge the counter would expire takes priority.
                    if (mem_ack) begin
                        instruction <= mem_rdata;
                        cur_pc      <= pc;
                        instr_valid <= 1'b1;
                        wait_cnt    <= '0;
                        mem_req     <= 1'b0;
                        state       <= HOLD;
                    end else begin
                        wait_cnt <= cnt_inc;
                        if (timed_out) begin
                            mem_req <= 1'b0;
                            fault   <= 1'b1;
                            state   <= FAULT;
                        end
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        if (branch_misaligned) begin
                            fault <= 1'b1;
                            state <= FAULT;
                        end else begin
                            pc      <= next_pc;
                            mem_req <= 1'b1;
                            state   <= REQ;
                        end
                    end
                end
                FAULT: begin
                    mem_req     <= 1'b0;
                    instr_valid <= 1'b0;
                    fault       <= 1'b1;
                end
                default: state <= FAULT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer (WORD=64, INSTR_LEN=32, RESET_PC=0, TIMEOUT=15).
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instruction;
    logic [63:0] cur_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        pc_src;
    logic [63:0] branch_target;
    logic        fault;

    int total = 0;
    int bad   = 0;

    fetch_sequencer #(
        .WORD      (64),
        .INSTR_LEN (32),
        .RESET_PC  (64'h0),
        .TIMEOUT   (15)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .instruction   (instruction),
        .cur_pc        (cur_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; mem_ack = 1'b0; mem_rdata = '0; instr_ready = 1'b0;
        pc_src = 1'b0; branch_target = '0;
        #2;
        chk("rst_req",   64'(mem_req), 64'd0);
        chk("rst_addr",  mem_addr, 64'd0);
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_instr", 64'(instruction), 64'd0);
        chk("rst_pc",    cur_pc, 64'd0);
        step();
        reset = 1'b0;

        // zero-wait memory, decode always ready: addresses 0,4,8,12
        mem_ack = 1'b1; mem_rdata = 32'hA000_0000; instr_ready = 1'b1;
        step();  // IDLE -> REQ, ack ignored while IDLE
        chk("idle_req",   64'(mem_req), 64'd1);
        chk("idle_addr",  mem_addr, 64'd0);
        chk("idle_valid", 64'(instr_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("seq_valid", 64'(instr_valid), 64'd1);
            chk("seq_curpc", cur_pc, 64'(4 * i));
            chk("seq_instr", 64'(instruction), 64'(32'hA000_0000 + i));
            chk("seq_req0",  64'(mem_req), 64'd0);
            mem_rdata = 32'hA000_0000 + 32'(i + 1);
            pc_src = i[0]; branch_target = 64'hDEAD_0000;  // ignored unless... consumed with pc_src
            pc_src = 1'b0;
            step();
            chk("seq_addr",  mem_addr, 64'(4 * (i + 1)));
            chk("seq_req1",  64'(mem_req), 64'd1);
            chk("seq_vld0",  64'(instr_valid), 64'd0);
        end

        // three wait cycles at address 12, then ack with 0x8B020020
        mem_ack = 1'b0; instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wait_req",  64'(mem_req), 64'd1);
            chk("wait_addr", mem_addr, 64'd12);
        end
        mem_ack = 1'b1; mem_rdata = 32'h8B02_0020;
        step();
        chk("wait_instr", 64'(instruction), 64'h8B02_0020);
        chk("wait_valid", 64'(instr_valid), 64'd1);
        chk("wait_curpc", cur_pc, 64'd12);
        chk("wait_reqlo", 64'(mem_req), 64'd0);

        // advance to 0x10 and stall there
        mem_ack = 1'b0; instr_ready = 1'b1;
        step();
        chk("to10_addr", mem_addr, 64'h10);
        mem_ack = 1'b1; mem_rdata = 32'h1111_1111; instr_ready = 1'b0;
        step();
        chk("to10_curpc", cur_pc, 64'h10);
        for (int i = 0; i < 5; i++) begin
            pc_src = 1'b1; branch_target = 64'h200;
            mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;  // ack outside REQ is ignored
            step();
            chk("stall_valid", 64'(instr_valid), 64'd1);
            chk("stall_curpc", cur_pc, 64'h10);
            chk("stall_instr", 64'(instruction), 64'h1111_1111);
            chk("stall_req",   64'(mem_req), 64'd0);
        end
        mem_ack = 1'b0; instr_ready = 1'b1; pc_src = 1'b1; branch_target = 64'h100;
        step();
        chk("redir_addr",  mem_addr, 64'h100);
        chk("redir_req",   64'(mem_req), 64'd1);
        chk("redir_valid", 64'(instr_valid), 64'd0);

        // ack exactly on the 15th REQ edge wins over the timeout
        instr_ready = 1'b0; pc_src = 1'b0;
        for (int i = 0; i < 14; i++) step();
        chk("t14_req",   64'(mem_req), 64'd1);
        chk("t14_fault", 64'(fault), 64'd0);
        mem_ack = 1'b1; mem_rdata = 32'h0F0F_0F0F;
        step();
        chk("t15_valid", 64'(instr_valid), 64'd1);
        chk("t15_fault", 64'(fault), 64'd0);
        chk("t15_curpc", cur_pc, 64'h100);

        // redirect to 0x40, then reset in the middle of the request
        mem_ack = 1'b0; instr_ready = 1'b1; pc_src = 1'b1; branch_target = 64'h40;
        step();
        chk("r40_addr", mem_addr, 64'h40);
        instr_ready = 1'b0; pc_src = 1'b0;
        step();
        chk("r40_req", 64'(mem_req), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_req",  64'(mem_req), 64'd0);
        chk("arst_addr", mem_addr, 64'd0);
        mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;  // late ack for abandoned request
        step();
        reset = 1'b0;
        step();
        chk("stale_req",   64'(mem_req), 64'd1);
        chk("stale_valid", 64'(instr_valid), 64'd0);
        chk("stale_instr", 64'(instruction), 64'd0);
        chk("stale_addr",  mem_addr, 64'd0);

        // PC wrap: all-ones-minus-3 plus 4 gives 0 with no fault
        mem_rdata = 32'hA5A5_A5A5;
        step();
        chk("w0_instr", 64'(instruction), 64'hA5A5_A5A5);
        mem_ack = 1'b0; instr_ready = 1'b1; pc_src = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        chk("wtop_addr", mem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        mem_ack = 1'b1; mem_rdata = 32'h5A5A_5A5A; instr_ready = 1'b0; pc_src = 1'b0;
        step();
        chk("wtop_curpc", cur_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        mem_ack = 1'b0; instr_ready = 1'b1;
        step();
        chk("wrap_addr",  mem_addr, 64'd0);
        chk("wrap_fault", 64'(fault), 64'd0);

        // no ack at all: fault after 15 REQ cycles, sticky
        instr_ready = 1'b0;
        for (int i = 0; i < 14; i++) step();
        chk("to14_req", 64'(mem_req), 64'd1);
        step();
        chk("to_fault", 64'(fault), 64'd1);
        chk("to_req",   64'(mem_req), 64'd0);
        chk("to_valid", 64'(instr_valid), 64'd0);
        chk("to_curpc", cur_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("to_instr", 64'(instruction), 64'h5A5A_5A5A);
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("sticky_fault", 64'(fault), 64'd1);
        chk("sticky_req",   64'(mem_req), 64'd0);
        chk("sticky_valid", 64'(instr_valid), 64'd0);

        // restart and consume with misaligned redirect target 0x102
        reset = 1'b1; mem_ack = 1'b0;
        step();
        reset = 1'b0;
        chk("rst2_fault", 64'(fault), 64'd0);
        step();
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        chk("al_valid", 64'(instr_valid), 64'd1);
        mem_ack = 1'b0; instr_ready = 1'b1; pc_src = 1'b1; branch_target = 64'h102;
        step();
`ifdef FETCH_ALIGN_CHECK_EN
        chk("al_fault", 64'(fault), 64'd1);
        chk("al_req",   64'(mem_req), 64'd0);
        chk("al_vld",   64'(instr_valid), 64'd0);
`else
        chk("al_fault", 64'(fault), 64'd0);
        chk("al_req",   64'(mem_req), 64'd1);
        chk("al_addr",  mem_addr, 64'h102);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Multi-cycle fetch controller that owns the program counter and drives the instruction memory with a request/acknowledge handshake, tolerating variable memory latency. It presents each fetched instruction to decode through a valid/ready handshake. On consumption it selects the next PC: sequential +4, or the branch target.
- Sits between the instruction memory and the decode stage.
- Replaces the free-running PC update with a stall-aware sequencer.

Parameters:
- WORD, 64, PC/address width in bits
- INSTR_LEN, 32, instruction width in bits
- RESET_PC, 0, PC value loaded on reset
- TIMEOUT, 15, max REQ cycles without mem_ack before fault; 0 disables timeout

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- mem_req  output  1  instruction memory request
- mem_addr  output  WORD  fetch address, stable while mem_req=1
- mem_ack  input  1  memory has returned mem_rdata this cycle
- mem_rdata  input  INSTR_LEN  instruction word from memory
- instruction  output  INSTR_LEN  registered fetched instruction
- cur_pc  output  WORD  address of the presented instruction
- instr_valid  output  1  instruction/cur_pc valid to decode
- instr_ready  input  1  decode accepts instruction this cycle
- pc_src  input  1  1 = next PC is branch_target, sampled only at consume
- branch_target  input  WORD  redirect address
- fault  output  1  sticky fetch fault

Behaviour:
- Reset (async assert, any state):
  - state=IDLE, internal pc=RESET_PC, cur_pc=RESET_PC.
  - mem_req=0, mem_addr=RESET_PC, instruction=0, instr_valid=0, fault=0, timeout counter=0.
- State IDLE:
  - Occupies one cycle after reset deassertion, then moves to REQ.
- State REQ:
  - mem_req=1, mem_addr=pc (registered, constant for the whole request).
  - Counter increments each REQ cycle without mem_ack.
  - On mem_ack at a rising edge: instruction<=mem_rdata, cur_pc<=pc, instr_valid<=1, counter<=0, go HOLD.
  - Same-cycle ack (zero-wait memory) is legal and gives 1 REQ cycle.
- Timeout:
  - When TIMEOUT>0 and the counter reaches TIMEOUT without ack, go FAULT.
  - If mem_ack arrives on the same edge the counter reaches TIMEOUT, the ack wins.
- State HOLD:
  - mem_req=0; instruction, cur_pc and instr_valid are held stable until instr_ready=1.
  - On instr_valid&instr_ready: pc<=(pc_src ? branch_target : cur_pc+4), instr_valid<=0, go REQ.
- pc_src and branch_target are ignored in all cycles except the consume cycle.
- Arithmetic: cur_pc+4 is modulo 2^WORD; all-ones-minus-3 wraps to 0, no fault.
- mem_ack outside REQ is ignored; mem_rdata is ignored unless mem_ack=1 in REQ.
- Throughput: best case one instruction per 2 cycles (REQ+HOLD). Latency from consume edge to mem_req=1 is 1 cycle.
- State FAULT:
  - fault=1, mem_req=0, instr_valid=0, sticky until reset.
  - instruction and cur_pc retain their last values.
- Reset mid-request drops mem_req immediately (asynchronously). An ack for the abandoned request arriving in IDLE is ignored.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN
- Defined:
  - At the consume cycle, if pc_src=1 and branch_target[1:0]!=0, go FAULT instead of REQ. No request is issued.
  - RESET_PC with nonzero low bits causes FAULT directly from IDLE.
- Undefined:
  - No alignment check; branch_target is used verbatim as mem_addr.

Test Plan:
- Reset with RESET_PC=0, memory acks in the same cycle, instr_ready=1, pc_src=0 -> mem_addr sequence 0,4,8,12, one instr_valid pulse every 2 cycles, cur_pc matches each fetched address.
- Memory acks after 3 wait cycles with rdata=0x8B020020 -> mem_req high for 4 cycles with mem_addr constant, then instruction=0x8B020020 and instr_valid=1.
- instr_valid=1 at cur_pc=0x10, instr_ready held 0 for 5 cycles, then 1 with pc_src=1, branch_target=0x100 -> outputs stable during the stall; next mem_addr=0x100; pc_src pulses during the stall have no effect.
- TIMEOUT=15, mem_ack never asserted -> fault=1 after 15 REQ cycles, mem_req=0 and stays so. mem_ack on exactly the 15th edge -> normal capture, no fault.
- Async reset asserted mid-REQ at pc=0x40, then late mem_ack -> mem_req=0 immediately, restart at RESET_PC, stale ack ignored.
- FETCH_ALIGN_CHECK_EN defined, consume with pc_src=1, branch_target=0x102 -> fault=1, no request. Undefined -> mem_addr=0x102.
